// File: rtl/mac_seq_multiplier_if.sv
// Operand/product handshake bundle for the sequential multiplier.
interface mac_seq_multiplier_if #(
  parameter int unsigned WIDTH = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic                   busy;
  logic                   out_valid;
  logic                   out_ready;
  logic [2*WIDTH-1:0]     product;
  logic [WIDTH-1:0]       product_lo;

  // Producer/consumer side of the multiplier.
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, busy, out_valid, product, product_lo
  );

  // Multiplier side.
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, busy, out_valid, product, product_lo
  );
endinterface

// File: rtl/mac_seq_multiplier.sv
// Shift-and-add unsigned multiplier, one multiplier bit per cycle.
// product_lo feeds operand a of the downstream accumulate adder.
module mac_seq_multiplier #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          EARLY_EXIT = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  mac_seq_multiplier_if.slave  bus
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0] mplr_q, mplr_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   product_q, product_d;
  logic [PW-1:0]   acc_sum;
  logic            last_iter;

  // Next-state and datapath update for accept, iterate and hand-off.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplr_d    = mplr_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    acc_sum   = mplr_q[0] ? PW'(acc_q + mcand_q) : acc_q;
    last_iter = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          mcand_d = PW'(bus.a);
          mplr_d  = bus.b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        mcand_d   = mcand_q << 1;
        mplr_d    = mplr_q >> 1;
        cnt_d     = CW'(cnt_q + CW'(1));
        acc_d     = acc_sum;
        // Early exit once no set multiplier bits remain to be added.
        last_iter = (cnt_q == CW'(WIDTH - 1)) ||
                    (EARLY_EXIT && (mplr_d == '0));
        if (last_iter) begin
          product_d = acc_sum;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        // Product is held until the consumer takes it; new operands are ignored.
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      mplr_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplr_q    <= mplr_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  // Status decoded from registered state; in_ready is also masked by reset.
  assign bus.in_ready   = (state_q == S_IDLE) && !rst;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.out_valid  = (state_q == S_DONE);
  assign bus.product    = product_q;
  assign bus.product_lo = product_q[WIDTH-1:0];

endmodule

// File: tb/tb_mac_seq_multiplier.sv
// Self-checking bench: directed vector table, multi-cycle corner cases and
// a random scoreboard run against both EARLY_EXIT variants.
module tb_mac_seq_multiplier;

  localparam int unsigned W = 8;

  logic       clk = 1'b0;
  logic [1:0] rst;

  always #5 clk = ~clk;

  mac_seq_multiplier_if #(.WIDTH(W)) if0 ();
  mac_seq_multiplier_if #(.WIDTH(W)) if1 ();

  mac_seq_multiplier #(.WIDTH(W), .EARLY_EXIT(1'b0)) u_dut0 (
    .clk (clk),
    .rst (rst[0]),
    .bus (if0.slave)
  );

  mac_seq_multiplier #(.WIDTH(W), .EARLY_EXIT(1'b1)) u_dut1 (
    .clk (clk),
    .rst (rst[1]),
    .bus (if1.slave)
  );

  // Indexed views of both buses.
  logic [1:0]     in_valid_w, in_ready_w, busy_w, out_valid_w, out_ready_w;
  logic [W-1:0]   a_w [2];
  logic [W-1:0]   b_w [2];
  logic [2*W-1:0] product_w [2];
  logic [W-1:0]   plo_w [2];

  assign in_valid_w  = {if1.in_valid,  if0.in_valid};
  assign in_ready_w  = {if1.in_ready,  if0.in_ready};
  assign busy_w      = {if1.busy,      if0.busy};
  assign out_valid_w = {if1.out_valid, if0.out_valid};
  assign out_ready_w = {if1.out_ready, if0.out_ready};
  assign a_w[0] = if0.a;
  assign a_w[1] = if1.a;
  assign b_w[0] = if0.b;
  assign b_w[1] = if1.b;
  assign product_w[0] = if0.product;
  assign product_w[1] = if1.product;
  assign plo_w[0] = if0.product_lo;
  assign plo_w[1] = if1.product_lo;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  task automatic set_in(input int sel, input logic v, input logic [W-1:0] av,
                        input logic [W-1:0] bv);
    if (sel == 0) begin
      if0.in_valid = v; if0.a = av; if0.b = bv;
    end else begin
      if1.in_valid = v; if1.a = av; if1.b = bv;
    end
  endtask

  task automatic set_ordy(input int sel, input logic v);
    if (sel == 0) if0.out_ready = v;
    else          if1.out_ready = v;
  endtask

  // Scoreboard: push a*b at each accept, pop and compare at each hand-off.
  logic [2*W-1:0] sbq0 [$];
  logic [2*W-1:0] sbq1 [$];
  int n_out = 0;

  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (rst[s]) begin
        if (s == 0) sbq0.delete();
        else        sbq1.delete();
      end else begin
        if (in_valid_w[s] && in_ready_w[s]) begin
          if (s == 0) sbq0.push_back((2*W)'(a_w[s]) * (2*W)'(b_w[s]));
          else        sbq1.push_back((2*W)'(a_w[s]) * (2*W)'(b_w[s]));
        end
        if (out_valid_w[s] && out_ready_w[s]) begin
          logic [2*W-1:0] exp_p;
          int sz;
          sz = (s == 0) ? sbq0.size() : sbq1.size();
          n_out++;
          if (sz == 0) begin
            check($sformatf("sb_spurious_out%0d", s), 32'(product_w[s]), 32'hFFFF_FFFF);
          end else begin
            exp_p = (s == 0) ? sbq0.pop_front() : sbq1.pop_front();
            check($sformatf("sb_product%0d", s), 32'(product_w[s]), 32'(exp_p));
            check($sformatf("sb_product_lo%0d", s), 32'(plo_w[s]), 32'(exp_p[W-1:0]));
          end
        end
      end
    end
  end

  // One full transaction with out_ready held low until out_valid; returns latency.
  task automatic run_op(input int sel, input logic [W-1:0] av, input logic [W-1:0] bv,
                        output logic [2*W-1:0] prod, output int lat);
    set_in(sel, 1'b1, av, bv);
    @(negedge clk);
    check("pre_accept_in_ready", 32'(in_ready_w[sel]), 32'd1);
    @(posedge clk); #1;
    set_in(sel, 1'b0, ~av, ~bv);
    lat = 0;
    while (!out_valid_w[sel] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    prod = product_w[sel];
    set_ordy(sel, 1'b1);
    @(posedge clk); #1;
    set_ordy(sel, 1'b0);
    check("post_take_out_valid", 32'(out_valid_w[sel]), 32'd0);
  endtask

  typedef struct {
    int             sel;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] prod;
    int             lat;
  } vec_t;

  vec_t vecs [9];
  int   drv_done;

  task automatic rand_drive(input int sel, input int n);
    for (int i = 0; i < n; i++) begin
      int   gap;
      int   k;
      logic r;
      gap = $urandom_range(0, 3);
      repeat (gap) begin @(posedge clk); #1; end
      set_in(sel, 1'b1, W'($urandom), W'($urandom));
      k = 0;
      forever begin
        @(negedge clk);
        r = in_ready_w[sel];
        @(posedge clk); #1;
        if (r) break;
        k++;
        if (k > 100) begin
          check($sformatf("rand_accept_timeout%0d", sel), 32'd1, 32'd0);
          break;
        end
      end
      set_in(sel, 1'b0, W'($urandom), W'($urandom));
    end
    drv_done++;
  endtask

  initial begin
    logic [2*W-1:0] p;
    int             lat;
    logic           seen;

    vecs[0] = '{0, 8'd13,  8'd11,  16'h008F, 8};
    vecs[1] = '{0, 8'd255, 8'd255, 16'hFE01, 8};
    vecs[2] = '{0, 8'd0,   8'd200, 16'h0000, 8};
    vecs[3] = '{0, 8'd200, 8'd0,   16'h0000, 8};
    vecs[4] = '{1, 8'h37,  8'h00,  16'h0000, 1};
    vecs[5] = '{1, 8'hA5,  8'h01,  16'h00A5, 1};
    vecs[6] = '{1, 8'h11,  8'h05,  16'h0055, 3};
    vecs[7] = '{1, 8'h03,  8'h80,  16'h0180, 8};
    vecs[8] = '{1, 8'd255, 8'd255, 16'hFE01, 8};

    rst = 2'b11;
    drv_done = 0;
    set_in(0, 1'b0, '0, '0);
    set_in(1, 1'b0, '0, '0);
    set_ordy(0, 1'b0);
    set_ordy(1, 1'b0);

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready0", 32'(in_ready_w[0]), 32'd0);
    check("rst_in_ready1", 32'(in_ready_w[1]), 32'd0);
    check("rst_busy0", 32'(busy_w[0]), 32'd0);
    check("rst_out_valid0", 32'(out_valid_w[0]), 32'd0);
    check("rst_product0", 32'(product_w[0]), 32'd0);
    check("rst_product1", 32'(product_w[1]), 32'd0);
    rst = 2'b00;
    #1;
    check("idle_in_ready0", 32'(in_ready_w[0]), 32'd1);

    // Directed vector table.
    foreach (vecs[i]) begin
      run_op(vecs[i].sel, vecs[i].a, vecs[i].b, p, lat);
      check($sformatf("vec%0d_product", i), 32'(p), 32'(vecs[i].prod));
      check($sformatf("vec%0d_product_lo", i), 32'(p[W-1:0]), 32'(vecs[i].prod[W-1:0]));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
    end

    // Back-pressure in DONE with operand pulses that must be ignored.
    set_in(0, 1'b1, 8'h21, 8'h13);
    @(posedge clk); #1;
    set_in(0, 1'b0, 8'h00, 8'h00);
    lat = 0;
    while (!out_valid_w[0] && lat < 40) begin @(posedge clk); #1; lat++; end
    check("bp_latency", 32'(lat), 32'd8);
    for (int c = 0; c < 5; c++) begin
      set_in(0, c[0], 8'hFF, W'(c + 1));
      @(negedge clk);
      check($sformatf("bp_in_ready_c%0d", c), 32'(in_ready_w[0]), 32'd0);
      @(posedge clk); #1;
      check($sformatf("bp_product_c%0d", c), 32'(product_w[0]), 32'h0273);
      check($sformatf("bp_out_valid_c%0d", c), 32'(out_valid_w[0]), 32'd1);
    end
    set_in(0, 1'b0, 8'h00, 8'h00);
    set_ordy(0, 1'b1);
    @(posedge clk); #1;
    set_ordy(0, 1'b0);
    check("bp_release_out_valid", 32'(out_valid_w[0]), 32'd0);
    check("bp_release_busy", 32'(busy_w[0]), 32'd0);
    check("bp_release_in_ready", 32'(in_ready_w[0]), 32'd1);
    check("bp_product_kept", 32'(product_w[0]), 32'h0273);

    // Reset during the fourth RUN cycle abandons the operation.
    set_in(0, 1'b1, 8'h55, 8'h77);
    @(posedge clk); #1;
    set_in(0, 1'b0, 8'h00, 8'h00);
    set_ordy(0, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    rst[0] = 1'b1;
    @(negedge clk);
    check("midrun_rst_in_ready", 32'(in_ready_w[0]), 32'd0);
    check("midrun_busy", 32'(busy_w[0]), 32'd1);
    @(posedge clk); #1;
    rst[0] = 1'b0;
    check("midrun_rst_busy", 32'(busy_w[0]), 32'd0);
    check("midrun_rst_product", 32'(product_w[0]), 32'd0);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid_w[0]) seen = 1'b1;
    end
    check("midrun_no_out_valid", 32'(seen), 32'd0);
    @(posedge clk); #1;
    set_ordy(0, 1'b0);
    run_op(0, 8'd7, 8'd9, p, lat);
    check("post_rst_product", 32'(p), 32'd63);
    check("post_rst_latency", 32'(lat), 32'd8);

    // Random traffic on both variants with random consumer back-pressure.
    fork
      rand_drive(0, 500);
      rand_drive(1, 500);
      begin
        while (drv_done != 2) begin
          @(posedge clk); #1;
          set_ordy(0, 1'($urandom_range(0, 1)));
          set_ordy(1, 1'($urandom_range(0, 1)));
        end
      end
    join
    set_ordy(0, 1'b1);
    set_ordy(1, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    check("drain_sb0_empty", 32'(sbq0.size()), 32'd0);
    check("drain_sb1_empty", 32'(sbq1.size()), 32'd0);
    check("drain_idle0", 32'(busy_w[0]), 32'd0);
    check("drain_idle1", 32'(busy_w[1]), 32'd0);
    check("total_outputs", 32'(n_out), 32'd1011);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
